// File: rtl/multi_sample_timer_pkg.sv
// Shared types and defaults for the multi-channel sample-trigger generator.
package multi_sample_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  localparam int          DEF_CNT_W   = 16;
  localparam int          DEF_NUM_CH  = 4;
  localparam int          DEF_BURST_W = 8;
  localparam logic [15:0] DEF_PERIOD  = 16'd400;

endpackage

// File: rtl/sample_phase_channel.sv
// One trigger channel: strobes one cycle after the frame counter hits its phase.
module sample_phase_channel
  import multi_sample_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] phase,
  input  logic [CNT_W-1:0] period_active,
  output logic             trigger
);

  logic trig_q, trig_d;

  // A phase beyond the active period is parked and never fires.
  assign trig_d  = run && (count == phase) && (phase <= period_active);
  assign trigger = trig_q;

  // Register the strobe so every channel output is a clean flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig_q <= 1'b0;
    else          trig_q <= trig_d;
  end

endmodule

// File: rtl/multi_sample_timer.sv
// Programmable multi-channel sample-trigger generator: one shared frame
// counter, per-channel phase offsets, continuous or N-frame burst runs.
module multi_sample_timer
  import multi_sample_timer_pkg::*;
#(
  parameter int               CNT_W          = DEF_CNT_W,
  parameter int               NUM_CH         = DEF_NUM_CH,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = DEF_PERIOD,
  parameter int               BURST_W        = DEF_BURST_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic [BURST_W-1:0]      burst_len,
  input  logic [CNT_W-1:0]        period_in,
  input  logic                    period_load,
  input  logic [NUM_CH*CNT_W-1:0] ch_phase,
  output logic [NUM_CH-1:0]       sample_trigger,
  output logic                    busy,
  output logic                    done,
  output logic [BURST_W-1:0]      frame_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   act_q, act_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               pv_q, pv_d;
  logic [BURST_W-1:0] fc_q, fc_d, fc_inc;
  logic [BURST_W-1:0] blen_q, blen_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               wrap, apply, run_ch;

  // >= so a count left above a freshly shortened period wraps at once.
  assign wrap   = (state_q == ST_RUN) && (count_q >= act_q);
  assign fc_inc = fc_q + 1'b1;
  // An aborted cycle must not produce a trigger.
  assign run_ch = (state_q == ST_RUN) && !stop;

  // Next-state: run control, frame counting, pending-period hand-over.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fc_d    = fc_q;
    blen_d  = blen_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    act_d   = act_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    apply   = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      mode_d  = mode;
      blen_d  = burst_len;
      fc_d    = '0;
      count_d = '0;
      apply   = 1'b1;
      if (mode == MODE_BURST && burst_len == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (wrap) begin
        count_d = '0;
        apply   = 1'b1;
        fc_d    = (fc_q == '1) ? fc_q : fc_inc;
        if (mode_q == MODE_BURST && fc_inc == blen_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
    if (apply && pv_q) begin
      act_d = pend_q;
      pv_d  = 1'b0;
    end
    // While idle there is no frame to protect, so a load takes effect directly.
    if (period_load) begin
      pend_d = period_in;
      if (state_q == ST_IDLE) begin
        act_d = period_in;
        pv_d  = 1'b0;
      end else begin
        pv_d  = 1'b1;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      act_q   <= DEFAULT_PERIOD;
      pend_q  <= DEFAULT_PERIOD;
      pv_q    <= 1'b0;
      fc_q    <= '0;
      blen_q  <= '0;
      mode_q  <= MODE_CONT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      fc_q    <= fc_d;
      blen_q  <= blen_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign frame_count = fc_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sample_phase_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .run          (run_ch),
      .count        (count_q),
      .phase        (ch_phase[i*CNT_W +: CNT_W]),
      .period_active(act_q),
      .trigger      (sample_trigger[i])
    );
  end

endmodule
